// File: rtl/ex_stage.sv
// ex_stage: execute stage with operand forwarding, ALU, branch resolution, iterative MUL and EX/MEM register
module alu (
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);
   always_comb begin
      y = '0;
      case (op)
         4'd0:    y = a + b;
         4'd1:    y = a - b;
         4'd2:    y = a & b;
         4'd3:    y = a | b;
         4'd4:    y = a ^ b;
         4'd5:    y = {31'b0, $signed(a) < $signed(b)};
         4'd6:    y = {31'b0, a < b};
         4'd7:    y = a << b[4:0];
         4'd8:    y = a >> b[4:0];
         4'd9:    y = $unsigned($signed(a) >>> b[4:0]);
         default: y = '0;
      endcase
   end
endmodule

module ex_stage #(
   parameter bit MUL_ENABLE = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_rs1_data,
   input  logic [31:0] id_rs2_data,
   input  logic [31:0] id_imm,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic [4:0]  id_rd_addr,
   input  logic [2:0]  id_funct3,
   input  logic        id_funct7_5,
   input  logic [6:0]  id_ctrl,
   input  logic        fwd_mem_en,
   input  logic [4:0]  fwd_mem_rd,
   input  logic [31:0] fwd_mem_data,
   input  logic        fwd_wb_en,
   input  logic [4:0]  fwd_wb_rd,
   input  logic [31:0] fwd_wb_data,
   input  logic        mem_stall,
   input  logic        flush,
   output logic        ex_stall,
   output logic        branch_taken,
   output logic [31:0] branch_target,
   output logic        exmem_valid,
   output logic [31:0] exmem_result,
   output logic [31:0] exmem_store_data,
   output logic [4:0]  exmem_rd_addr,
   output logic [2:0]  exmem_funct3,
   output logic [2:0]  exmem_ctrl
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nxt;
   logic [31:0] rs1, rs2, op_b, alu_y, mul_a, mul_b, mul_p;
   logic [4:0] cnt;
   logic [3:0] alu_op;
   logic is_rtype, alu_src, is_branch, is_mul, mul_start, fsm_stall, cond, lt, ltu;
   assign {is_rtype, alu_src, is_branch} = id_ctrl[6:4];
   assign is_mul = MUL_ENABLE && id_ctrl[3];
   // MEM beats WB; x0 is never forwarded
   assign rs1 = (fwd_mem_en && fwd_mem_rd == id_rs1_addr && fwd_mem_rd != 5'd0) ? fwd_mem_data :
                (fwd_wb_en && fwd_wb_rd == id_rs1_addr && fwd_wb_rd != 5'd0) ? fwd_wb_data : id_rs1_data;
   assign rs2 = (fwd_mem_en && fwd_mem_rd == id_rs2_addr && fwd_mem_rd != 5'd0) ? fwd_mem_data :
                (fwd_wb_en && fwd_wb_rd == id_rs2_addr && fwd_wb_rd != 5'd0) ? fwd_wb_data : id_rs2_data;
   assign op_b = alu_src ? id_imm : rs2;
   always_comb begin
      alu_op = 4'd0;
      case (id_funct3)
         3'b000: alu_op = (is_rtype && id_funct7_5) ? 4'd1 : 4'd0;
         3'b001: alu_op = 4'd7;
         3'b010: alu_op = 4'd5;
         3'b011: alu_op = 4'd6;
         3'b100: alu_op = 4'd4;
         3'b101: alu_op = id_funct7_5 ? 4'd9 : 4'd8;
         3'b110: alu_op = 4'd3;
         3'b111: alu_op = 4'd2;
      endcase
   end
   alu u_alu (.op(alu_op), .a(rs1), .b(op_b), .y(alu_y));
   assign lt  = $signed(rs1) < $signed(rs2);
   assign ltu = rs1 < rs2;
   always_comb begin
      cond = 1'b0;
      case (id_funct3)
         3'b000:  cond = rs1 == rs2;
         3'b001:  cond = rs1 != rs2;
         3'b100:  cond = lt;
         3'b101:  cond = !lt;
         3'b110:  cond = ltu;
         3'b111:  cond = !ltu;
         default: cond = 1'b0;
      endcase
   end
   assign mul_start = id_valid && is_mul && !flush;
   always_comb begin
      state_nxt = state;
      fsm_stall = 1'b0;
      case (state)
         IDLE: begin
            fsm_stall = mul_start;
            state_nxt = mul_start ? BUSY : IDLE;
         end
         BUSY: begin
            fsm_stall = 1'b1;
            state_nxt = (cnt == 5'd31) ? DONE : BUSY;
         end
         DONE: begin
            fsm_stall = mem_stall;
            state_nxt = mem_stall ? DONE : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end
   assign ex_stall      = fsm_stall || mem_stall;
   assign branch_taken  = id_valid && is_branch && cond && !flush && !ex_stall;
   assign branch_target = id_pc + id_imm;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         mul_a <= '0;
         mul_b <= '0;
         mul_p <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && mul_start) begin
            mul_a <= rs1;
            mul_b <= rs2;
            mul_p <= '0;
            cnt   <= '0;
         end else if (state == BUSY) begin
            mul_p <= mul_b[0] ? mul_p + mul_a : mul_p;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            cnt   <= cnt + 5'd1;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exmem_valid      <= 1'b0;
         exmem_result     <= '0;
         exmem_store_data <= '0;
         exmem_rd_addr    <= '0;
         exmem_funct3     <= '0;
         exmem_ctrl       <= '0;
      end else if (!mem_stall) begin
         if (fsm_stall || flush || !id_valid) begin
            exmem_valid <= 1'b0;
            exmem_ctrl  <= '0;
         end else begin
            exmem_valid      <= 1'b1;
            exmem_result     <= (state == DONE) ? mul_p : alu_y;
            exmem_store_data <= rs2;
            exmem_rd_addr    <= id_rd_addr;
            exmem_funct3     <= id_funct3;
            exmem_ctrl       <= is_branch ? 3'b000 : id_ctrl[2:0];
         end
      end
   end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage
module tb_ex_stage;
   logic        clk = 1'b0, rst_n;
   logic        id_valid, id_funct7_5, fwd_mem_en, fwd_wb_en, mem_stall, flush;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, fwd_mem_data, fwd_wb_data;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, fwd_mem_rd, fwd_wb_rd;
   logic [2:0]  id_funct3;
   logic [6:0]  id_ctrl;
   logic        ex_stall, branch_taken, exmem_valid;
   logic [31:0] branch_target, exmem_result, exmem_store_data;
   logic [4:0]  exmem_rd_addr;
   logic [2:0]  exmem_funct3, exmem_ctrl;
   int n_chk = 0, n_fail = 0, n_stall, n_bad;
   localparam logic [6:0] C_R = 7'b1000100, C_I = 7'b0100100, C_ST = 7'b0100001,
                          C_BR = 7'b0010000, C_MUL = 7'b1001100;

   ex_stage #(.MUL_ENABLE(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_funct3(id_funct3), .id_funct7_5(id_funct7_5), .id_ctrl(id_ctrl),
      .fwd_mem_en(fwd_mem_en), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
      .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .mem_stall(mem_stall), .flush(flush), .ex_stall(ex_stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .exmem_valid(exmem_valid), .exmem_result(exmem_result),
      .exmem_store_data(exmem_store_data), .exmem_rd_addr(exmem_rd_addr),
      .exmem_funct3(exmem_funct3), .exmem_ctrl(exmem_ctrl)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear();
      id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
      id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_funct3 = 0; id_funct7_5 = 0;
      id_ctrl = 0; fwd_mem_en = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
      fwd_wb_en = 0; fwd_wb_rd = 0; fwd_wb_data = 0; mem_stall = 0; flush = 0;
   endtask

   task automatic instr(input logic [6:0] c, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
      id_valid = 1; id_ctrl = c; id_funct3 = f3; id_funct7_5 = f7;
      id_rs1_data = a; id_rs2_data = b; id_imm = imm;
   endtask

   initial begin
      clear();
      rst_n = 0;
      #12;
      chk1("rst_valid", exmem_valid, 0);
      chk("rst_result", exmem_result, 0);
      chk("rst_ctrl", 32'(exmem_ctrl), 0);
      chk1("rst_stall", ex_stall, 0);
      chk1("rst_bt", branch_taken, 0);
      rst_n = 1;
      tick();
      // forwarding priority and x0 exclusion
      instr(C_R, 3'b000, 0, 32'h99, 0, 0);
      id_rs1_addr = 5; id_rd_addr = 7;
      fwd_mem_en = 1; fwd_mem_rd = 5; fwd_mem_data = 32'h11;
      fwd_wb_en = 1; fwd_wb_rd = 5; fwd_wb_data = 32'h22;
      tick();
      chk("fwd_mem", exmem_result, 32'h11);
      chk1("fwd_valid", exmem_valid, 1);
      chk("fwd_ctrl", 32'(exmem_ctrl), 3'b100);
      chk("fwd_rd", 32'(exmem_rd_addr), 7);
      fwd_mem_en = 0;
      tick();
      chk("fwd_wb", exmem_result, 32'h22);
      fwd_mem_en = 1; fwd_mem_rd = 0; fwd_wb_rd = 0; id_rs1_addr = 0;
      tick();
      chk("fwd_x0", exmem_result, 32'h99);
      fwd_mem_rd = 6; id_rs2_addr = 6; id_rs2_data = 32'h5;
      tick();
      chk("fwd_rs2_store", exmem_store_data, 32'h11);
      chk("fwd_rs2_sum", exmem_result, 32'haa);
      clear();
      // ALU decode
      instr(C_R, 3'b101, 1, 32'h80000000, 4, 0);
      tick();
      chk("sra", exmem_result, 32'hF8000000);
      id_funct7_5 = 0;
      tick();
      chk("srl", exmem_result, 32'h08000000);
      instr(C_R, 3'b000, 1, 10, 3, 0);
      tick();
      chk("sub", exmem_result, 7);
      instr(C_I, 3'b000, 1, 5, 0, 1);
      tick();
      chk("addi_f7", exmem_result, 6);
      instr(C_R, 3'b010, 0, 32'hFFFFFFFF, 1, 0);
      tick();
      chk("slt", exmem_result, 1);
      id_funct3 = 3'b011;
      tick();
      chk("sltu", exmem_result, 0);
      instr(C_ST, 3'b000, 0, 32'h100, 32'hABCD, 8);
      tick();
      chk("st_addr", exmem_result, 32'h108);
      chk("st_data", exmem_store_data, 32'hABCD);
      chk("st_ctrl", 32'(exmem_ctrl), 3'b001);
      // branches
      instr(C_BR, 3'b100, 0, 32'hFFFFFFFF, 1, 32'h20);
      id_pc = 32'h100; id_rd_addr = 0;
      #1;
      chk1("blt_taken", branch_taken, 1);
      chk("blt_target", branch_target, 32'h120);
      tick();
      chk1("br_valid", exmem_valid, 1);
      chk("br_ctrl", 32'(exmem_ctrl), 0);
      id_funct3 = 3'b110;
      #1;
      chk1("bltu_not", branch_taken, 0);
      id_funct3 = 3'b100; flush = 1;
      #1;
      chk1("flush_beats_br", branch_taken, 0);
      tick();
      chk1("flush_bubble", exmem_valid, 0);
      flush = 0; id_funct3 = 3'b000; id_rs1_data = 5; id_rs2_data = 5;
      #1;
      chk1("beq_taken", branch_taken, 1);
      id_funct3 = 3'b010;
      #1;
      chk1("f3_010_never", branch_taken, 0);
      clear();
      tick();
      // MUL: 0xFFFFFFFF * 3
      instr(C_MUL, 3'b000, 0, 32'hFFFFFFFF, 3, 0);
      id_rd_addr = 9;
      #1;
      n_stall = 0; n_bad = 0;
      while (ex_stall && n_stall < 40) begin
         n_stall++;
         if (exmem_valid) n_bad++;
         tick();
      end
      chk("mul_stall_cycles", n_stall, 33);
      chk("mul_valid_during", n_bad, 0);
      chk1("mul_done_pre", exmem_valid, 0);
      tick();
      chk("mul_result", exmem_result, 32'hFFFFFFFD);
      chk1("mul_valid", exmem_valid, 1);
      chk("mul_rd", 32'(exmem_rd_addr), 9);
      id_valid = 0;
      #1;
      chk1("mul_idle_stall", ex_stall, 0);
      tick();
      chk1("mul_one_beat", exmem_valid, 0);
      // MUL with mem_stall held in DONE
      instr(C_MUL, 3'b000, 0, 32'h12345678, 32'h10, 0);
      #1;
      n_stall = 0;
      while (ex_stall && n_stall < 40) begin
         n_stall++;
         tick();
      end
      chk("mul2_stall_cycles", n_stall, 33);
      mem_stall = 1;
      #1;
      chk1("done_mem_stall", ex_stall, 1);
      tick();
      tick();
      chk1("done_hold_valid", exmem_valid, 0);
      mem_stall = 0;
      tick();
      chk("mul2_result", exmem_result, 32'h23456780);
      chk1("mul2_valid", exmem_valid, 1);
      clear();
      // mem_stall holding a taken beq
      instr(C_I, 3'b000, 0, 32'h1000, 0, 32'h10);
      id_rd_addr = 3;
      tick();
      chk("pre_hold", exmem_result, 32'h1010);
      instr(C_BR, 3'b000, 0, 7, 7, 32'h40);
      id_pc = 32'h200; mem_stall = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk1("hold_bt", branch_taken, 0);
         chk1("hold_stall", ex_stall, 1);
         tick();
         chk("hold_result", exmem_result, 32'h1010);
         chk("hold_ctrl", 32'(exmem_ctrl), 3'b100);
      end
      flush = 1;
      tick();
      chk1("flush_no_clear_held", exmem_valid, 1);
      chk("flush_held_ctrl", 32'(exmem_ctrl), 3'b100);
      flush = 0; mem_stall = 0;
      #1;
      chk1("release_bt", branch_taken, 1);
      chk("release_target", branch_target, 32'h240);
      tick();
      chk1("release_valid", exmem_valid, 1);
      chk("release_ctrl", 32'(exmem_ctrl), 0);
      id_valid = 0;
      #1;
      chk1("release_pulse_end", branch_taken, 0);
      tick();
      // reset during BUSY at count 10
      instr(C_MUL, 3'b000, 0, 7, 6, 0);
      for (int i = 0; i < 11; i++) tick();
      chk1("busy_stall", ex_stall, 1);
      id_valid = 0; rst_n = 0;
      #1;
      chk1("rst_mid_stall", ex_stall, 0);
      chk1("rst_mid_valid", exmem_valid, 0);
      chk("rst_mid_result", exmem_result, 0);
      chk("rst_mid_rd", 32'(exmem_rd_addr), 0);
      #3 rst_n = 1;
      n_bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ex_stall || exmem_valid) n_bad++;
      end
      chk("rst_no_result", n_bad, 0);
      // flush during BUSY at count 5
      instr(C_MUL, 3'b000, 0, 7, 6, 0);
      for (int i = 0; i < 6; i++) tick();
      flush = 1;
      tick();
      clear();
      #1;
      chk1("flush_idle", ex_stall, 0);
      n_bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ex_stall || exmem_valid) n_bad++;
      end
      chk("flush_no_result", n_bad, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. Consumes ID/EX register outputs, resolves operand forwarding, decodes the 4-bit ALU control, instantiates alu, and resolves branches.
- Runs a multi-cycle iterative MUL behind a stall FSM.
- Owns the EX/MEM pipeline register feeding the memory stage.

Parameters:
MUL_ENABLE, 1, 1 = iterative MUL FSM present; 0 = id_ctrl[3] ignored, op decoded as normal ALU op

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID/EX holds a live instruction
id_pc  in  32  instruction PC
id_rs1_data  in  32  register-file rs1 value
id_rs2_data  in  32  register-file rs2 value
id_imm  in  32  sign-extended immediate
id_rs1_addr  in  5  rs1 index
id_rs2_addr  in  5  rs2 index
id_rd_addr  in  5  rd index
id_funct3  in  3  funct3
id_funct7_5  in  1  instr bit 30
id_ctrl  in  7  {is_rtype, alu_src, is_branch, is_mul, reg_write, mem_read, mem_write}, bit6..0
fwd_mem_en / fwd_mem_rd / fwd_mem_data  in  1/5/32  MEM-stage writeback forward
fwd_wb_en / fwd_wb_rd / fwd_wb_data  in  1/5/32  WB-stage writeback forward
mem_stall  in  1  downstream hold
flush  in  1  kill instruction in EX
ex_stall  out  1  freeze IF/ID and ID/EX
branch_taken  out  1  redirect request, one pulse per taken branch
branch_target  out  32  id_pc + id_imm (mod 2^32)
exmem_valid  out  1  EX/MEM live
exmem_result  out  32  ALU or MUL result
exmem_store_data  out  32  forwarded rs2
exmem_rd_addr  out  5  rd
exmem_funct3  out  3  load/store size
exmem_ctrl  out  3  {reg_write, mem_read, mem_write}

Behaviour:
- Reset (async, rst_n=0): all exmem_* = 0, FSM = IDLE, MUL regs = 0. Outputs ex_stall, branch_taken = 0 (inputs-qualified).
- Forwarding, per operand:
  - fwd_mem when en and rd == src and rd != 0; else fwd_wb under the same rule; else id_*_data.
  - MEM beats WB. x0 is never forwarded.
- ALU B operand = alu_src ? id_imm : forwarded rs2.
- ALU control from funct3:
  - 000: add; sub only if is_rtype and f7_5.
  - 001 sll, 010 slt, 011 sltu, 100 xor.
  - 101: srl; sra if f7_5, for R- and I-type.
  - 110 or, 111 and.
  - Encodings: add 0, sub 1, and 2, or 3, xor 4, slt 5, sltu 6, sll 7, srl 8, sra 9.
- Branch compare on forwarded rs1/rs2:
  - 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu; 010/011 never taken.
  - branch_taken = id_valid & is_branch & cond & ~flush & ~ex_stall.
  - Combinational; asserted only in the cycle the branch advances.
- Branch instruction still enters EX/MEM with ctrl forced 000.
- MUL FSM, states IDLE -> BUSY -> DONE -> IDLE:
  - IDLE, id_valid & is_mul & ~flush: ex_stall = 1; latch forwarded rs1/rs2, count = 0; go BUSY.
  - BUSY: shift-add one multiplier bit per cycle; ex_stall = 1; after 32 cycles (count 31) go DONE.
  - DONE: ex_stall = mem_stall; result = low 32 bits of product (sign-agnostic); when ~mem_stall, capture into EX/MEM and go IDLE.
  - ex_stall is high for exactly 33 cycles when mem_stall = 0.
- EX/MEM update each edge:
  - mem_stall = 1: hold all fields; ex_stall = 1.
  - Else if ex_stall from FSM, or flush, or ~id_valid: bubble (exmem_valid = 0, exmem_ctrl = 0; other fields don't-care but hold).
  - Else: capture result, store data, rd, funct3, ctrl.
- flush: FSM to IDLE synchronously from any state; in-flight MUL discarded. Does not clear a held EX/MEM under mem_stall.
- Simultaneous flush and branch: flush wins; no branch_taken.
- Reset mid-MUL: FSM IDLE immediately; no result emitted.

Test Plan:
- fwd_mem rd=5 data=0x11, fwd_wb rd=5 data=0x22, id add rs1=5 rs2=0 -> exmem_result=0x11. Repeat with rd=0 on both -> uses id_rs1_data.
- R-type funct3=101 f7_5=1, rs1=0x80000000, rs2=4 -> 0xF8000000; funct3=000 f7_5=1 I-type imm=1, rs1=5 -> 6 (add, not sub).
- blt rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> single-cycle branch_taken=1, target=0x120; bltu same operands -> 0.
- MUL 0xFFFFFFFF*3 -> ex_stall high 33 cycles, exmem_valid=0 throughout, then exmem_result=0xFFFFFFFD, valid=1 for one beat.
- mem_stall=1 for 3 cycles with taken beq in EX -> EX/MEM held, ex_stall=1, branch_taken=0 until release, then one pulse.
- rst_n low at BUSY count 10, then MUL flushed at count 5 -> FSM IDLE, exmem_* = 0, no MUL result appears.
